// File: rtl/ac_pkg.sv
// Shared constants and parameter legality check for the SSM2603 I2S link.
// The stereo sample struct is declared in ac_i2s_link because its width follows DATA_W.
package ac_pkg;

  localparam int SLOTS_PER_FRAME = 64;
  localparam int SLOTS_PER_CH    = 32;

  function automatic bit ac_params_ok(input int data_w, input int bclk_half, input int mclk_div);
    return (data_w >= 8) && (data_w <= 31) && (bclk_half >= 4) &&
           (mclk_div >= 2) && ((mclk_div % 2) == 0);
  endfunction

endpackage

// File: rtl/ac_clk_gen.sv
// Codec clock generator: free-running MCLK, BCLK divider, 64-slot frame counter
// and the rise/fall/frame-start strobes, all decoded from registered state.
module ac_clk_gen
  import ac_pkg::*;
#(
  parameter int BCLK_HALF = 8,
  parameter int MCLK_DIV  = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic       o_mclk,
  output logic       o_bclk,
  output logic [5:0] o_slot_cnt,
  output logic       o_rise,
  output logic       o_fall,
  output logic       o_frame_start
);

  localparam int                 DIV_W    = $clog2(BCLK_HALF);
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(BCLK_HALF - 1);
  localparam int                 MCK_W    = $clog2(MCLK_DIV);
  localparam logic [MCK_W-1:0]   MCK_LAST = MCK_W'(MCLK_DIV / 2 - 1);
  localparam logic [5:0]         SLOT_LAST = 6'(SLOTS_PER_FRAME - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic [MCK_W-1:0] r_mck_cnt;
  logic             r_bclk;
  logic             r_mclk;
  logic [5:0]       r_slot_cnt;
  logic             w_tc;

  // A strobe is high in the cycle before the edge on which BCLK changes.
  assign w_tc          = (r_div_cnt == DIV_LAST);
  assign o_rise        = w_tc & ~r_bclk;
  assign o_fall        = w_tc & r_bclk;
  assign o_frame_start = o_fall & (r_slot_cnt == SLOT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt  <= '0;
      r_mck_cnt  <= '0;
      r_bclk     <= 1'b0;
      r_mclk     <= 1'b0;
      r_slot_cnt <= '0;
    end else begin
      r_mck_cnt <= (r_mck_cnt == MCK_LAST) ? '0 : r_mck_cnt + 1'b1;
      if (r_mck_cnt == MCK_LAST) r_mclk <= ~r_mclk;
      r_div_cnt <= w_tc ? '0 : r_div_cnt + 1'b1;
      if (w_tc) r_bclk <= ~r_bclk;
      if (o_fall) r_slot_cnt <= r_slot_cnt + 1'b1;
    end
  end

  assign o_mclk     = r_mclk;
  assign o_bclk     = r_bclk;
  assign o_slot_cnt = r_slot_cnt;

endmodule

// File: rtl/ac_i2s_link.sv
// I2S master link for the SSM2603: DAC serializer, ADC deserializer and frame-aligned mute.
// Standard I2S framing, MSB first with a one-slot delay after each LRCK edge.
module ac_i2s_link
  import ac_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int BCLK_HALF = 8,
  parameter int MCLK_DIV  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [2*DATA_W-1:0] dacData,
  input  logic                dacValid,
  output logic                dacReady,
  output logic                dacUnderflow,
  output logic [2*DATA_W-1:0] adcData,
  output logic                adcValid,
  output logic                audMclk,
  output logic                audBclk,
  output logic                audAdcLrck,
  output logic                audDacLrck,
  output logic                audDacData,
  input  logic                audAdcData,
  output logic                audMute
);

  typedef struct packed {
    logic [DATA_W-1:0] left;
    logic [DATA_W-1:0] right;
  } acStereo_t;

  localparam int         SR_W    = SLOTS_PER_FRAME - 1;
  localparam logic [5:0] L_FIRST = 6'd1;
  localparam logic [5:0] L_LAST  = 6'(DATA_W);
  localparam logic [5:0] R_FIRST = 6'(SLOTS_PER_CH + 1);
  localparam logic [5:0] R_LAST  = 6'(SLOTS_PER_CH + DATA_W);

  if (!ac_params_ok(DATA_W, BCLK_HALF, MCLK_DIV)) begin : g_bad_params
    $error("ac_i2s_link: illegal DATA_W/BCLK_HALF/MCLK_DIV combination");
  end

  logic             w_mclk;
  logic             w_bclk;
  logic [5:0]       w_slot_cnt;
  logic             w_rise;
  logic             w_fall;
  logic             w_frame_start;
  logic             w_data_slot;
  acStereo_t        w_dac_in;
  logic [SR_W-1:0]  w_dac_frame;

  logic [SR_W-1:0]      r_dac_sr;
  logic                 r_dac_bit;
  logic                 r_mute;
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_rise_d1;
  logic                 r_rise_d2;
  logic                 r_cap_done;
  logic                 r_adc_valid;
  logic [2*DATA_W-1:0]  r_adc_sr;
  acStereo_t            r_adc_data;

  ac_clk_gen #(
    .BCLK_HALF (BCLK_HALF),
    .MCLK_DIV  (MCLK_DIV)
  ) u_clk_gen (
    .clk           (clk),
    .reset         (reset),
    .o_mclk        (w_mclk),
    .o_bclk        (w_bclk),
    .o_slot_cnt    (w_slot_cnt),
    .o_rise        (w_rise),
    .o_fall        (w_fall),
    .o_frame_start (w_frame_start)
  );

  // Frame image for slots 1..63, slot 1 in the MSB; an underflow loads all zeros.
  assign w_dac_in    = dacValid ? dacData : '0;
  assign w_dac_frame = (SR_W'(w_dac_in.left)  << (SR_W - DATA_W)) |
                       (SR_W'(w_dac_in.right) << (SR_W - SLOTS_PER_CH - DATA_W));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dac_sr  <= '0;
      r_dac_bit <= 1'b0;
      r_mute    <= 1'b0;
    end else if (w_frame_start) begin
      r_dac_sr  <= w_dac_frame;
      r_dac_bit <= 1'b0;
      r_mute    <= en;
    end else if (w_fall) begin
      r_dac_bit <= r_dac_sr[SR_W-1];
      r_dac_sr  <= {r_dac_sr[SR_W-2:0], 1'b0};
    end
  end

  assign w_data_slot = ((w_slot_cnt >= L_FIRST) && (w_slot_cnt <= L_LAST)) ||
                       ((w_slot_cnt >= R_FIRST) && (w_slot_cnt <= R_LAST));

  // Sampling two cycles after the rise picks up the bit that was on the pin at the rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_rise_d1   <= 1'b0;
      r_rise_d2   <= 1'b0;
      r_cap_done  <= 1'b0;
      r_adc_valid <= 1'b0;
      r_adc_sr    <= '0;
      r_adc_data  <= '0;
    end else begin
      r_sync1     <= audAdcData;
      r_sync2     <= r_sync1;
      r_rise_d1   <= w_rise;
      r_rise_d2   <= r_rise_d1;
      r_cap_done  <= 1'b0;
      r_adc_valid <= 1'b0;
      if (r_rise_d2 && w_data_slot) begin
        r_adc_sr   <= {r_adc_sr[2*DATA_W-2:0], r_sync2};
        r_cap_done <= (w_slot_cnt == R_LAST);
      end
      if (r_cap_done) begin
        r_adc_data  <= r_adc_sr;
        r_adc_valid <= 1'b1;
      end
    end
  end

  assign dacReady     = w_frame_start;
  assign dacUnderflow = w_frame_start & ~dacValid;
  assign adcData      = r_adc_data;
  assign adcValid     = r_adc_valid;
  assign audMclk      = w_mclk;
  assign audBclk      = w_bclk;
  assign audAdcLrck   = w_slot_cnt[5];
  assign audDacLrck   = w_slot_cnt[5];
  assign audDacData   = r_dac_bit;
  assign audMute      = r_mute;

endmodule
